// File: rtl/dmem_axil_bridge_if.sv
// dmem_axil_bridge_if: AXI4-Lite master/slave bundle between the data-memory bridge and the interconnect
interface dmem_axil_bridge_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/dmem_axil_bridge.sv
// dmem_axil_bridge: turns core load/store requests into single AXI4-Lite transactions, stalling the core meanwhile
module dmem_axil_bridge #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wr_en_i,
    input  logic              mem_rd_en_i,
    input  logic [ADDR_W-1:0] addr_wr_i,
    input  logic [ADDR_W-1:0] addr_rd_i,
    input  logic [DATA_W-1:0] data_wr_i,
    input  logic [STRB_W-1:0] strb_wr_i,
    output logic [DATA_W-1:0] data_rd_o,
    output logic              stall_mem_o,
    output logic              bus_err_o,
    dmem_axil_bridge_if.master axi
);
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_e;
    state_e            state_q, state_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic              arvalid_q, arvalid_d, rready_q, rready_d;
    logic              pend_q, pend_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        pend_d    = pend_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_wr_en_i) begin
                    addr_d    = addr_wr_i;
                    wdata_d   = data_wr_i;
                    strb_d    = strb_wr_i;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    pend_d    = mem_rd_en_i;
                    state_d   = WR;
                end else if (mem_rd_en_i) begin
                    addr_d    = addr_rd_i;
                    arvalid_d = 1'b1;
                    state_d   = RD_ADDR;
                end
            end
            WR: begin
                // AW and W channels retire independently; move on once neither is still offered
                awvalid_d = awvalid_q && !axi.awready;
                wvalid_d  = wvalid_q && !axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.bvalid) begin
                    bready_d = 1'b0;
                    err_d    = err_q | (axi.bresp != 2'b00);
                    pend_d   = 1'b0;
                    addr_d   = pend_q ? addr_rd_i : addr_q;
                    arvalid_d = pend_q;
                    state_d  = pend_q ? RD_ADDR : DONE;
                end
            end
            RD_ADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi.rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = (axi.rresp == 2'b00) ? axi.rdata : '0;
                    err_d    = err_q | (axi.rresp != 2'b00);
                    state_d  = DONE;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
        end
    end
    assign stall_mem_o = (state_q == IDLE) ? (mem_wr_en_i || mem_rd_en_i) : (state_q != DONE);
    assign bus_err_o   = (state_q == DONE) && err_q;
    assign data_rd_o   = rdata_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = strb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
endmodule

// File: tb/tb_dmem_axil_bridge.sv
// tb_dmem_axil_bridge: directed vectors with a queued scoreboard checked at each DONE cycle
module tb_dmem_axil_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_wr_en = 1'b0, mem_rd_en = 1'b0;
    logic [63:0] addr_wr = '0, addr_rd = '0, data_wr = '0;
    logic [7:0]  strb_wr = '0;
    logic [63:0] data_rd;
    logic        stall, bus_err, req;

    dmem_axil_bridge_if #(.ADDR_W(64), .DATA_W(64), .STRB_W(8)) axi ();

    dmem_axil_bridge #(.ADDR_W(64), .DATA_W(64), .STRB_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_wr_en_i(mem_wr_en), .mem_rd_en_i(mem_rd_en),
        .addr_wr_i(addr_wr), .addr_rd_i(addr_rd),
        .data_wr_i(data_wr), .strb_wr_i(strb_wr),
        .data_rd_o(data_rd), .stall_mem_o(stall), .bus_err_o(bus_err),
        .axi(axi.master)
    );

    always #5 clk = ~clk;
    assign req = mem_wr_en || mem_rd_en;

    typedef struct {
        bit wr; bit rd;
        logic [63:0] waddr; logic [63:0] wdata; logic [7:0] wstrb;
        logic [63:0] raddr; logic [63:0] rdata;
        logic [1:0] bresp; logic [1:0] rresp;
        int awd; int wdd; int ard;
        int stall; int aw_cyc; int w_cyc; int ar_cyc;
        logic [63:0] edata; bit eerr;
    } vec_t;

    int n_chk = 0, n_fail = 0, done_cnt = 0;
    vec_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // AXI-Lite slave with programmable per-channel wait states
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [63:0] r_data_cfg = '0;
    int          aw_c = 0, w_c = 0, ar_c = 0, r_c = 0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    logic        aw_dn = 1'b0, w_dn = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [63:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [7:0]  cap_wstrb = '0;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign axi.awready = axi.awvalid && (aw_c >= aw_dly);
    assign axi.wready  = axi.wvalid && (w_c >= w_dly);
    assign axi.bvalid  = b_pend;
    assign axi.bresp   = b_resp_cfg;
    assign axi.arready = axi.arvalid && (ar_c >= ar_dly);
    assign axi.rvalid  = r_pend && (r_c >= r_dly);
    assign axi.rdata   = r_data_cfg;
    assign axi.rresp   = r_resp_cfg;
    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign b_hs  = axi.bvalid && axi.bready;
    assign ar_hs = axi.arvalid && axi.arready;
    assign r_hs  = axi.rvalid && axi.rready;

    always @(posedge clk) begin
        if (rst) begin
            aw_c <= 0; w_c <= 0; ar_c <= 0; r_c <= 0;
            aw_dn <= 1'b0; w_dn <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_c <= aw_hs ? 0 : aw_c + int'(axi.awvalid);
            w_c  <= w_hs ? 0 : w_c + int'(axi.wvalid);
            ar_c <= ar_hs ? 0 : ar_c + int'(axi.arvalid);
            r_c  <= r_hs ? 0 : r_c + int'(r_pend && !axi.rvalid);
            if ((aw_dn || aw_hs) && (w_dn || w_hs)) begin
                b_pend <= 1'b1; aw_dn <= 1'b0; w_dn <= 1'b0;
            end else begin
                aw_dn <= aw_dn || aw_hs; w_dn <= w_dn || w_hs;
                if (b_hs) b_pend <= 1'b0;
            end
            if (ar_hs) r_pend <= 1'b1;
            else if (r_hs) r_pend <= 1'b0;
            if (aw_hs) begin n_aw <= n_aw + 1; cap_awaddr <= axi.awaddr; end
            if (w_hs) begin n_w <= n_w + 1; cap_wdata <= axi.wdata; cap_wstrb <= axi.wstrb; end
            if (b_hs) n_b <= n_b + 1;
            if (ar_hs) begin n_ar <= n_ar + 1; cap_araddr <= axi.araddr; end
            if (r_hs) n_r <= n_r + 1;
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each DONE cycle
    initial begin
        int b_aw = 0, b_w = 0, b_b = 0, b_ar = 0, b_r = 0;
        int st_cnt = 0, aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
        logic aw_wait = 1'b0, w_wait = 1'b0, ar_wait = 1'b0;
        logic [63:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
        vec_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar; b_r = n_r;
                st_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                aw_wait = 1'b0; w_wait = 1'b0; ar_wait = 1'b0;
            end else begin
                if (axi.awvalid && aw_wait) chk("awaddr_stable", axi.awaddr, p_awaddr);
                if (axi.wvalid && w_wait) chk("wdata_stable", axi.wdata, p_wdata);
                if (axi.arvalid && ar_wait) chk("araddr_stable", axi.araddr, p_araddr);
                aw_wait = axi.awvalid && !axi.awready; p_awaddr = axi.awaddr;
                w_wait = axi.wvalid && !axi.wready; p_wdata = axi.wdata;
                ar_wait = axi.arvalid && !axi.arready; p_araddr = axi.araddr;
                if (axi.arvalid && exp_q.size() > 0 && exp_q[0].wr) chk("b_before_ar", 64'(n_b - b_b), 64'd1);
                st_cnt += int'(req && stall);
                aw_cnt += int'(axi.awvalid);
                w_cnt  += int'(axi.wvalid);
                ar_cnt += int'(axi.arvalid);
                if (req && !stall) begin
                    if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("stall_cycles", 64'(st_cnt), 64'(e.stall));
                        chk("data_rd", data_rd, e.edata);
                        chk("bus_err", {63'd0, bus_err}, {63'd0, e.eerr});
                        chk("n_aw", 64'(n_aw - b_aw), 64'(e.wr));
                        chk("n_w", 64'(n_w - b_w), 64'(e.wr));
                        chk("n_b", 64'(n_b - b_b), 64'(e.wr));
                        chk("n_ar", 64'(n_ar - b_ar), 64'(e.rd));
                        chk("n_r", 64'(n_r - b_r), 64'(e.rd));
                        if (e.wr) begin
                            chk("awaddr", cap_awaddr, e.waddr);
                            chk("wdata", cap_wdata, e.wdata);
                            chk("wstrb", {56'd0, cap_wstrb}, {56'd0, e.wstrb});
                            chk("aw_cycles", 64'(aw_cnt), 64'(e.aw_cyc));
                            chk("w_cycles", 64'(w_cnt), 64'(e.w_cyc));
                        end
                        if (e.rd) begin
                            chk("araddr", cap_araddr, e.raddr);
                            chk("ar_cycles", 64'(ar_cnt), 64'(e.ar_cyc));
                        end
                    end
                    b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar; b_r = n_r;
                    st_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                    done_cnt++;
                end else if (bus_err) chk("bus_err_outside_done", 64'd1, 64'd0);
            end
        end
    end

    task automatic txn(input vec_t v);
        int start;
        aw_dly = v.awd; w_dly = v.wdd; ar_dly = v.ard; r_dly = 0;
        b_resp_cfg = v.bresp; r_resp_cfg = v.rresp; r_data_cfg = v.rdata;
        exp_q.push_back(v);
        @(posedge clk); #1;
        start = done_cnt;
        mem_wr_en = v.wr; mem_rd_en = v.rd;
        addr_wr = v.waddr; data_wr = v.wdata; strb_wr = v.wstrb; addr_rd = v.raddr;
        for (int i = 0; i < 100 && done_cnt == start; i++) begin
            @(negedge clk); #1;
        end
        if (done_cnt == start) begin
            chk("done_timeout", 64'd1, 64'd0);
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        mem_wr_en = 1'b0; mem_rd_en = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs = '{
            '{1, 0, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'h0, 64'h0, 2'b00, 2'b00, 0, 0, 0,
              3, 1, 1, 0, 64'h0, 0},
            '{0, 1, 64'h0, 64'h0, 8'h00, 64'h8000_0010, 64'hDEADBEEFCAFEF00D, 2'b00, 2'b00, 0, 0, 4,
              7, 0, 0, 5, 64'hDEADBEEFCAFEF00D, 0},
            '{1, 0, 64'h8000_0020, 64'hA5A5A5A5A5A5A5A5, 8'h0F, 64'h0, 64'h0, 2'b00, 2'b00, 3, 0, 0,
              6, 4, 1, 0, 64'hDEADBEEFCAFEF00D, 0},
            '{1, 0, 64'h8000_0028, 64'h0123456789ABCDEF, 8'hF0, 64'h0, 64'h0, 2'b00, 2'b00, 0, 3, 0,
              6, 1, 4, 0, 64'hDEADBEEFCAFEF00D, 0},
            '{1, 1, 64'h8000_0030, 64'h5555555555555555, 8'hFF, 64'h8000_0040, 64'h0F0F0F0F0F0F0F0F, 2'b00, 2'b00, 0, 0, 0,
              5, 1, 1, 1, 64'h0F0F0F0F0F0F0F0F, 0},
            '{0, 1, 64'h0, 64'h0, 8'h00, 64'h8000_0050, 64'h1234, 2'b00, 2'b10, 0, 0, 0,
              3, 0, 0, 1, 64'h0, 1},
            '{0, 1, 64'h0, 64'h0, 8'h00, 64'h8000_0058, 64'hCAFEBABE00000001, 2'b00, 2'b00, 0, 0, 0,
              3, 0, 0, 1, 64'hCAFEBABE00000001, 0},
            '{1, 0, 64'h8000_0068, 64'h00000000000000AA, 8'h01, 64'h0, 64'h0, 2'b11, 2'b00, 0, 0, 0,
              3, 1, 1, 0, 64'hCAFEBABE00000001, 1}
        };
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_awvalid", {63'd0, axi.awvalid}, 64'd0);
        chk("rst_wvalid", {63'd0, axi.wvalid}, 64'd0);
        chk("rst_bready", {63'd0, axi.bready}, 64'd0);
        chk("rst_arvalid", {63'd0, axi.arvalid}, 64'd0);
        chk("rst_rready", {63'd0, axi.rready}, 64'd0);
        chk("rst_data_rd", data_rd, 64'd0);
        chk("rst_bus_err", {63'd0, bus_err}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("prot", {58'd0, axi.awprot, axi.arprot}, 64'd0);
        foreach (vecs[i]) txn(vecs[i]);
        // Reset while waiting in RD_DATA aborts the load
        r_dly = 5; ar_dly = 0; r_resp_cfg = 2'b00; r_data_cfg = 64'h77;
        @(posedge clk); #1;
        mem_rd_en = 1'b1; addr_rd = 64'h8000_0070;
        for (int i = 0; i < 50 && !axi.rready; i++) @(negedge clk);
        chk("rready_seen", {63'd0, axi.rready}, 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_rready", {63'd0, axi.rready}, 64'd0);
        chk("abort_arvalid", {63'd0, axi.arvalid}, 64'd0);
        chk("abort_data_rd", data_rd, 64'd0);
        chk("abort_stall_req", {63'd0, stall}, 64'd1);
        mem_rd_en = 1'b0; #1;
        chk("abort_stall_noreq", {63'd0, stall}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        txn('{0, 1, 64'h0, 64'h0, 8'h00, 64'h8000_0060, 64'h00000000FFFF0000, 2'b00, 2'b00, 0, 0, 0,
              3, 0, 0, 1, 64'h00000000FFFF0000, 0});
        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
